// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch front end and IF/ID pipeline register.
// Keeps one instruction-memory request outstanding at a time. It presents the
// fetched instruction to ID, or a NOP bubble when no instruction is available.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_REQ  | request driven at pc, waiting for imem_ready
// S_WAIT | request accepted, waiting for imem_rvalid (r_drop = stale)
// S_HOLD | response parked in skid register while ID is stalled
module if_id_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hazard_detection_src,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_instruction,
    output logic            IF_ID_valid,
    output logic            fetch_busy
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_instr;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_instr;
    logic            r_ifid_valid;

    logic            w_resp_ok;
    logic            w_new_avail;
    logic [XLEN-1:0] w_new_pc;
    logic [XLEN-1:0] w_new_instr;
    logic [XLEN-1:0] w_branch_pc;
    logic [XLEN-1:0] w_pc_inc;

    // A usable instruction is either a fresh non-stale response or the skid entry.
    assign w_resp_ok   = (r_state == S_WAIT) && imem_rvalid && !r_drop;
    assign w_new_avail = w_resp_ok || (r_state == S_HOLD);
    assign w_new_pc    = (r_state == S_HOLD) ? r_skid_pc : r_pc;
    assign w_new_instr = (r_state == S_HOLD) ? r_skid_instr : imem_rdata;
    assign w_branch_pc = {branch_target[XLEN-1:2], 2'b00};
    assign w_pc_inc    = r_pc + XLEN'(4);

    // imem_req is gated by rst_n so no request is visible while reset is held.
    assign imem_req          = rst_n && (r_state == S_REQ);
    assign imem_addr         = r_pc;
    assign IF_ID_pc          = r_ifid_pc;
    assign IF_ID_instruction = r_ifid_instr;
    assign IF_ID_valid       = r_ifid_valid;
    assign fetch_busy        = (r_state != S_REQ);

    // Fetch FSM, PC, skid register and IF/ID register; a branch overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            r_pc         <= w_branch_pc;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            case (r_state)
                S_REQ: begin
                    // Accepted in the same cycle: its response belongs to the old path.
                    if (imem_ready) begin
                        r_state <= S_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                S_HOLD: r_state <= S_REQ;
                default: r_state <= S_REQ;
            endcase
        end else begin
            if (hazard_detection_src) begin
                if (w_new_avail) begin
                    r_ifid_pc    <= w_new_pc;
                    r_ifid_instr <= w_new_instr;
                    r_ifid_valid <= 1'b1;
                    r_pc         <= w_pc_inc;
                end else begin
                    r_ifid_valid <= 1'b0;
                    r_ifid_instr <= NOP_INSTR;
                end
            end
            case (r_state)
                S_REQ: begin
                    if (imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else if (hazard_detection_src) begin
                            r_state <= S_REQ;
                        end else begin
                            r_skid_pc    <= r_pc;
                            r_skid_instr <= imem_rdata;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hazard_detection_src) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: directed stimulus, a transaction-level model of
// the fetch front end, per-cycle comparison plus literal expectations.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hz;
    logic        br;
    logic [31:0] br_tgt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instruction;
    logic        IF_ID_valid;
    logic        fetch_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // model: fetch pc, one outstanding fetch (maybe stale), one parked instruction, IF/ID
    logic [31:0] m_pc;
    logic        m_pend;
    logic        m_stale;
    logic [31:0] m_pend_pc;
    logic        m_buf;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;

    // memory responder
    int          resp_wait = -1;
    int          resp_lat  = 0;
    logic [31:0] resp_addr = '0;

    if_id_fetch_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .hazard_detection_src(hz),
        .branch_taken        (br),
        .branch_target       (br_tgt),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .IF_ID_pc            (IF_ID_pc),
        .IF_ID_instruction   (IF_ID_instruction),
        .IF_ID_valid         (IF_ID_valid),
        .fetch_busy          (fetch_busy)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a ^ 32'h5A00_0000) | 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_pend     = 1'b0;
        m_stale    = 1'b0;
        m_pend_pc  = 32'h0;
        m_buf      = 1'b0;
        m_buf_pc   = 32'h0;
        m_buf_instr = NOP;
        m_id_pc    = 32'h0;
        m_id_instr = NOP;
        m_id_valid = 1'b0;
    endtask

    // One clock edge of the fetch front end, in transaction terms.
    task automatic model_step();
        logic        acc, got, have;
        logic [31:0] c_pc, c_in;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc  = !m_pend && !m_buf && imem_ready;
        got  = m_pend && imem_rvalid;
        have = 1'b0;
        c_pc = 32'h0;
        c_in = 32'h0;
        if (acc) begin
            resp_wait = resp_lat;
            resp_addr = m_pc;
        end
        if (br) begin
            m_pc       = {br_tgt[31:2], 2'b00};
            m_id_valid = 1'b0;
            m_id_instr = NOP;
            m_buf      = 1'b0;
            if (got) begin
                m_pend  = 1'b0;
                m_stale = 1'b0;
            end else if (m_pend) begin
                m_stale = 1'b1;
            end else if (acc) begin
                m_pend  = 1'b1;
                m_stale = 1'b1;
            end
        end else begin
            if (m_buf) begin
                have = 1'b1; c_pc = m_buf_pc; c_in = m_buf_instr;
            end else if (got && !m_stale) begin
                have = 1'b1; c_pc = m_pend_pc; c_in = imem_rdata;
            end
            if (got) begin
                m_pend  = 1'b0;
                m_stale = 1'b0;
            end
            if (acc) begin
                m_pend    = 1'b1;
                m_stale   = 1'b0;
                m_pend_pc = m_pc;
            end
            if (have && hz) begin
                m_id_pc    = c_pc;
                m_id_instr = c_in;
                m_id_valid = 1'b1;
                m_pc       = c_pc + 32'd4;
                m_buf      = 1'b0;
            end else if (have) begin
                m_buf       = 1'b1;
                m_buf_pc    = c_pc;
                m_buf_instr = c_in;
            end else if (hz) begin
                m_id_valid = 1'b0;
                m_id_instr = NOP;
            end
        end
    endtask

    task automatic compare_all();
        check("imem_req",    32'(imem_req),    32'(rst_n && !m_pend && !m_buf));
        check("imem_addr",   imem_addr,        m_pc);
        check("fetch_busy",  32'(fetch_busy),  32'(m_pend || m_buf));
        check("IF_ID_valid", 32'(IF_ID_valid), 32'(m_id_valid));
        check("IF_ID_pc",    IF_ID_pc,         m_id_pc);
        check("IF_ID_instr", IF_ID_instruction, m_id_instr);
    endtask

    // Edge: update model; then at negedge drive the memory response and compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (resp_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(resp_addr);
            resp_wait   = -1;
        end else begin
            if (resp_wait > 0) resp_wait--;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; hz = 1'b1; br = 1'b0; br_tgt = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        model_reset();
        repeat (2) cycle();

        // basic fetch stream
        rst_n = 1'b1;
        #1;
        check("lit_req_after_release", 32'(imem_req), 32'd1);
        check("lit_addr0", imem_addr, 32'h0);
        cycle();
        cycle();
        check("lit_first_valid", 32'(IF_ID_valid), 32'd1);
        check("lit_first_pc", IF_ID_pc, 32'h0);
        check("lit_first_instr", IF_ID_instruction, 32'h00A0_0093);
        check("lit_addr4", imem_addr, 32'h4);
        cycle();
        check("lit_bubble_valid", 32'(IF_ID_valid), 32'd0);
        check("lit_bubble_instr", IF_ID_instruction, NOP);
        check("lit_bubble_pc_kept", IF_ID_pc, 32'h0);
        cycle();
        check("lit_addr8", imem_addr, 32'h8);

        // stall across a response
        hz = 1'b0;
        cycle();
        cycle();
        check("lit_hold_busy", 32'(fetch_busy), 32'd1);
        check("lit_hold_noreq", 32'(imem_req), 32'd0);
        cycle();
        check("lit_hold_ifid_pc", IF_ID_pc, 32'h4);
        check("lit_hold_ifid_valid", 32'(IF_ID_valid), 32'd1);
        hz = 1'b1;
        cycle();
        check("lit_skid_pc8", IF_ID_pc, 32'h8);
        check("lit_addr12", imem_addr, 32'hC);

        // branch in WAIT, stale response one cycle later
        resp_lat = 1;
        cycle();
        br = 1'b1; br_tgt = 32'h0000_0100;
        cycle();
        br = 1'b0;
        cycle();
        check("lit_br_addr100", imem_addr, 32'h100);
        check("lit_br_stale_dropped", 32'(IF_ID_valid), 32'd0);
        resp_lat = 0;
        cycle();
        cycle();
        check("lit_br_ifid_pc100", IF_ID_pc, 32'h100);
        check("lit_br_ifid_valid", 32'(IF_ID_valid), 32'd1);

        // branch plus stall while HOLD
        hz = 1'b0;
        cycle();
        cycle();
        check("lit_hold2_busy", 32'(fetch_busy), 32'd1);
        br = 1'b1; br_tgt = 32'h0000_0200;
        cycle();
        check("lit_hold_br_valid", 32'(IF_ID_valid), 32'd0);
        check("lit_hold_br_nop", IF_ID_instruction, NOP);
        check("lit_hold_br_addr", imem_addr, 32'h200);
        check("lit_hold_br_req", 32'(imem_req), 32'd1);

        // branch while request accepted in same cycle, then pc wrap
        hz = 1'b1; br_tgt = 32'hFFFF_FFFC;
        cycle();
        br = 1'b0;
        cycle();
        cycle();
        cycle();
        check("lit_wrap_addr0", imem_addr, 32'h0);
        check("lit_wrap_ifid_pc", IF_ID_pc, 32'hFFFF_FFFC);

        // branch in REQ without ready, unaligned target
        imem_ready = 1'b0; br = 1'b1; br_tgt = 32'h0000_0103;
        cycle();
        check("lit_align_addr", imem_addr, 32'h100);
        br = 1'b0; imem_ready = 1'b1;
        cycle();
        // branch coinciding with a response in WAIT
        br = 1'b1; br_tgt = 32'h0000_0040;
        cycle();
        check("lit_br_rv_addr", imem_addr, 32'h40);
        check("lit_br_rv_req", 32'(imem_req), 32'd1);
        br = 1'b0; resp_lat = 2;
        cycle();

        // reset mid-WAIT with stray responses
        rst_n = 1'b0;
        model_reset();
        resp_wait = -1; resp_lat = 0;
        #1;
        check("lit_rst_req", 32'(imem_req), 32'd0);
        check("lit_rst_valid", 32'(IF_ID_valid), 32'd0);
        check("lit_rst_instr", IF_ID_instruction, NOP);
        check("lit_rst_busy", 32'(fetch_busy), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("lit_rst_rel_req", 32'(imem_req), 32'd1);
        check("lit_rst_rel_addr", imem_addr, 32'h0);
        cycle();
        cycle();
        check("lit_rst_first_pc", IF_ID_pc, 32'h0);
        check("lit_rst_first_instr", IF_ID_instruction, 32'h00A0_0093);
        check("lit_rst_first_valid", 32'(IF_ID_valid), 32'd1);
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch front end and IF/ID pipeline register for the 5-stage RISC-V core.
- Consumes the hazard unit's active-high proceed signal `hazard_detection_src`: 1 = advance, 0 = load-use stall.
- Consumes the EX-stage branch redirect.
- Drives a single-outstanding-request instruction-memory interface and presents PC and instruction to ID, inserting NOP bubbles when no valid instruction is available.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding presented on IF_ID_instruction when IF_ID_valid = 0 (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hazard_detection_src  input  1  1 = ID may consume IF/ID (advance); 0 = hold IF/ID and PC.
- branch_taken  input  1  redirect request from EX, single-cycle pulse.
- branch_target  input  XLEN  redirect PC, sampled when branch_taken = 1.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; always equals the current PC.
- imem_ready  input  1  memory accepts request this cycle (imem_req & imem_ready = handshake).
- imem_rvalid  input  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rdata  input  XLEN  fetched instruction.
- IF_ID_pc  output  XLEN  PC of instruction in IF/ID.
- IF_ID_instruction  output  XLEN  instruction in IF/ID (NOP_INSTR when invalid).
- IF_ID_valid  output  1  IF/ID holds a real instruction.
- fetch_busy  output  1  high in WAIT or HOLD (debug/perf).

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; state = REQ; drop flag = 0.
  - IF_ID_valid = 0, IF_ID_pc = 0, IF_ID_instruction = NOP_INSTR.
  - imem_req = 0 during reset. imem_req = 1 from the first cycle after release.
- States:
  - REQ: imem_req = 1, imem_addr = pc. On imem_ready go to WAIT.
  - WAIT: imem_req = 0. Await imem_rvalid.
  - HOLD: imem_req = 0. A response is buffered in the skid register while ID is stalled.
- WAIT with imem_rvalid = 1:
  - If drop = 1: discard the data, clear drop, go to REQ.
  - Else if hazard_detection_src = 1: IF/ID loads {pc, imem_rdata}, IF_ID_valid = 1, pc += 4, go to REQ.
  - Else: skid register loads {pc, imem_rdata}, go to HOLD.
- HOLD with hazard_detection_src = 1: IF/ID loads from the skid register, IF_ID_valid = 1, pc += 4, go to REQ.
- IF/ID when no new instruction is available:
  - hazard_detection_src = 1: IF_ID_valid = 0 and IF_ID_instruction = NOP_INSTR (bubble); IF_ID_pc keeps its last value.
  - hazard_detection_src = 0: IF/ID holds all fields unchanged (stall), whether valid or not.
- Branch (branch_taken = 1) takes priority over stall and over any response in the same cycle:
  - pc = branch_target; IF_ID_valid = 0 (NOP).
  - REQ, request not yet accepted: stay in REQ; imem_addr updates next cycle.
  - REQ with imem_ready in the same cycle: go to WAIT with drop = 1, because the in-flight fetch is stale.
  - WAIT without rvalid: set drop = 1, stay in WAIT.
  - WAIT with rvalid: discard the data, go to REQ.
  - HOLD: discard the skid contents, go to REQ.
- pc arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0. branch_target bits [1:0] are forced to 0.
- Latency: minimum 2 cycles from request acceptance to IF_ID_valid (ready in cycle N, rvalid in N+1, IF/ID updated at edge N+1).
- Throughput: one instruction per 2 cycles with single-cycle memory; one outstanding request only.
- Reset mid-operation: immediate return to reset values; any response arriving after reset release with no accepted request is ignored (imem_rvalid in REQ is ignored).

Test Plan:
- Reset, imem_ready = 1, rvalid one cycle after acceptance, rdata = 32'h00A00093 at PC 0 → imem_addr sequence 0, 4, 8; IF_ID_pc = 0 with IF_ID_valid = 1 two cycles after release; NOP with IF_ID_valid = 0 on cycles without a new instruction.
- hazard_detection_src = 0 for 3 cycles while a response arrives → state HOLD, IF/ID unchanged, no new imem_req; on release IF/ID takes buffered PC 8 and the next request addresses 12.
- branch_taken with target 32'h0000_0100 while in WAIT; stale rdata arrives next cycle → stale data dropped, IF_ID_valid = 0, next imem_addr = 32'h100, IF_ID_pc = 32'h100 after its response.
- branch_taken and hazard_detection_src = 0 in the same cycle while in HOLD → skid discarded, pc = target, IF/ID cleared to NOP.
- PC = 32'hFFFF_FFFC fetch completes → next imem_addr = 0; branch_target = 32'h0000_0103 → imem_addr = 32'h0000_0100.
- rst_n asserted mid-WAIT, rvalid pulsed during reset and in the cycle after release → outputs at reset values, response ignored, first request issued to RESET_PC.
